// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
//   Program engine that walks NUM_WORDS 16-bit SECDED codewords stored as
//   byte pairs starting at SRC_BASE. For each word it corrects a single-bit
//   error, flags a double-bit error, and writes the 11-bit message plus a
//   2-bit status flag back as a byte pair starting at DST_BASE.
//   Each word takes five states: RD_LO, RD_HI, DECODE, WR_LO, WR_HI.
//
//   Optional build macro: SECDED_STATS_EN
//     Adds the single_cnt / double_cnt outputs. Both are saturating 4-bit
//     counters of corrected and uncorrectable words. They clear on reset and
//     on every accepted req.
//
//   Codeword layout (bit 15..0):
//     d11 d10 d9 d8 d7 d6 d5 p8 d4 d3 d2 p4 d1 p2 p1 p0
//   Bit n (1..15) is Hamming position n. Bit 0 is the overall parity.

module hamming_secded_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  output logic              ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        mem_wr_data,
  output logic              mem_wr_en
`ifdef SECDED_STATS_EN
  ,
  output logic [3:0]        single_cnt,
  output logic [3:0]        double_cnt
`endif
);

  localparam int                IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

  localparam logic [1:0] FLAG_CLEAN  = 2'b00;
  localparam logic [1:0] FLAG_SINGLE = 2'b01;
  localparam logic [1:0] FLAG_DOUBLE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // XOR of the positions of all set bits among positions 1..15.
  function automatic logic [3:0] calc_syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int n = 1; n < 16; n++) begin
      if (cw[n]) s = s ^ 4'(n);
    end
    return s;
  endfunction

  // Status flag from syndrome and overall parity. Odd parity means one bit
  // flipped (possibly p0 itself). Even parity with a non-zero syndrome means
  // two bits flipped.
  function automatic logic [1:0] classify(input logic [3:0] s, input logic p);
    logic [1:0] f;
    if (p)              f = FLAG_SINGLE;
    else if (s != 4'd0) f = FLAG_DOUBLE;
    else                f = FLAG_CLEAN;
    return f;
  endfunction

  // Flip the bit named by the syndrome, but only for a single error.
  // A p0-only error (s == 0) leaves the payload untouched.
  function automatic logic [15:0] correct(input logic [15:0] cw,
                                          input logic [3:0]  s,
                                          input logic        p);
    logic [15:0] fixed;
    fixed = cw;
    if (p && (s != 4'd0)) fixed[s] = ~cw[s];
    return fixed;
  endfunction

  // Gather d11..d1 from their Hamming positions.
  function automatic logic [10:0] extract(input logic [15:0] cw);
    return {cw[15], cw[14], cw[13], cw[12], cw[11], cw[10], cw[9],
            cw[7],  cw[6],  cw[5],  cw[3]};
  endfunction

  // Saturating 4-bit increment for the statistics counters.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ack_q, ack_d;
  logic [7:0]        cw_lo_q, cw_lo_d;
  logic [7:0]        cw_hi_q, cw_hi_d;
  logic [7:0]        res_lo_q, res_lo_d;
  logic [7:0]        res_hi_q, res_hi_d;

  logic [15:0]       cw_w;
  logic [3:0]        syn_w;
  logic              par_w;
  logic [1:0]        flag_w;
  logic [15:0]       fixed_w;
  logic [10:0]       data_w;
  logic [ADDR_W-1:0] offs_w;
  logic              accept_w;

  assign cw_w     = {cw_hi_q, cw_lo_q};
  assign syn_w    = calc_syndrome(cw_w);
  assign par_w    = ^cw_w;
  assign flag_w   = classify(syn_w, par_w);
  assign fixed_w  = correct(cw_w, syn_w, par_w);
  assign data_w   = extract(fixed_w);
  assign offs_w   = ADDR_W'({idx_q, 1'b0});
  assign accept_w = (state_q == IDLE) && req;

  assign ack = ack_q;

  // State register; an asynchronous reset aborts any run immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Control and datapath registers: word index, ack, fetched bytes, result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      ack_q    <= 1'b0;
      cw_lo_q  <= 8'h00;
      cw_hi_q  <= 8'h00;
      res_lo_q <= 8'h00;
      res_hi_q <= 8'h00;
    end else begin
      idx_q    <= idx_d;
      ack_q    <= ack_d;
      cw_lo_q  <= cw_lo_d;
      cw_hi_q  <= cw_hi_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  // Next-state logic and memory port drive for the per-word sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ack_d       = ack_q;
    cw_lo_d     = cw_lo_q;
    cw_hi_d     = cw_hi_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    mem_addr    = '0;
    mem_wr_data = 8'h00;
    mem_wr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RD_LO;
          idx_d   = '0;
          ack_d   = 1'b0;
        end
      end
      RD_LO: begin
        mem_addr = SRC_A + offs_w;
        cw_lo_d  = mem_rd_data;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = SRC_A + offs_w + ADDR_W'(1);
        cw_hi_d  = mem_rd_data;
        state_d  = DECODE;
      end
      DECODE: begin
        res_lo_d = data_w[7:0];
        res_hi_d = {flag_w, 3'b000, data_w[10:8]};
        state_d  = WR_LO;
      end
      WR_LO: begin
        mem_addr    = DST_A + offs_w;
        mem_wr_en   = 1'b1;
        mem_wr_data = res_lo_q;
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_addr    = DST_A + offs_w + ADDR_W'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = res_hi_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD_LO;
        end
      end
      DONE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SECDED_STATS_EN
  logic [3:0] single_q, single_d;
  logic [3:0] double_q, double_d;

  assign single_cnt = single_q;
  assign double_cnt = double_q;

  // Error statistics: cleared on a new run, bumped once per decoded word.
  always_comb begin
    single_d = single_q;
    double_d = double_q;
    if (accept_w) begin
      single_d = 4'd0;
      double_d = 4'd0;
    end else if (state_q == DECODE) begin
      if (flag_w == FLAG_SINGLE) single_d = sat_inc4(single_q);
      if (flag_w == FLAG_DOUBLE) double_d = sat_inc4(double_q);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      single_q <= 4'd0;
      double_q <= 4'd0;
    end else begin
      single_q <= single_d;
      double_q <= double_d;
    end
  end
`else
  // Without the statistics option these signals have no consumer.
  logic unused_stats_w;
  assign unused_stats_w = accept_w ^ (^sat_inc4(4'd0));
`endif

endmodule
